// File: rtl/div16_if.sv
// Start/done coprocessor bus for div16. The Remainder signal exists only when
// DIV_REMAINDER_EN is defined.
interface div16_if #(parameter int WIDTH = 16);
  logic             init_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Result;
  logic             done;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] Remainder;
`endif

  modport master (
    output init_in, A, B,
`ifdef DIV_REMAINDER_EN
    input  Remainder,
`endif
    input  Result, done
  );

  modport slave (
    input  init_in, A, B,
`ifdef DIV_REMAINDER_EN
    output Remainder,
`endif
    output Result, done
  );
endinterface

// File: rtl/div16.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Define DIV_REMAINDER_EN to add the registered Remainder output.
module div16 #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  div16_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q, d, r;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_next, q_next;
  logic             r_ge, last_step;
  logic             load_op, calc_step, finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.init_in) state_next = CALC;
      CALC: if (last_step)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_op   = 1'b0;
    calc_step = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: load_op = bus.init_in;
      CALC: begin
        calc_step = 1'b1;
        finish    = last_step;
      end
      default: ;
    endcase
  end

  // The shifted remainder keeps its carry-out bit so the compare never overflows.
  always_comb begin
    r_shift   = {r, q[WIDTH-1]};
    r_ge      = (r_shift >= {1'b0, d});
    r_next    = r_ge ? (r_shift[WIDTH-1:0] - d) : r_shift[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], r_ge};
    last_step = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      d        <= '0;
      r        <= '0;
      count    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (load_op) begin
        q     <= bus.A;
        d     <= bus.B;
        r     <= '0;
        count <= '0;
      end else if (calc_step) begin
        q     <= q_next;
        r     <= r_next;
        count <= count + CW'(1);
      end
      if (finish) result_q <= q_next;
    end
  end

  assign bus.Result = result_q;
  assign bus.done   = done_q;

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_q;

  always_ff @(posedge clk) begin
    if (rst)         rem_q <= '0;
    else if (finish) rem_q <= r_next;
  end

  assign bus.Remainder = rem_q;
`endif

endmodule

// File: tb/tb_div16.sv
// Scoreboard testbench for div16: expected quotient/remainder pairs are queued
// at each start and compared when done pulses.
module tb_div16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  div16_if #(.WIDTH(W)) bus ();

  div16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drives a one-cycle start; returns at the falling edge after the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.A       = a;
    bus.B       = b;
    bus.init_in = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.init_in = 1'b0;
  endtask

  // Counts rising edges from the start edge until done, or -1 on timeout.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (lat < start + 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done === 1'b1) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    bus.init_in = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.Result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %0h expected 0", bus.Result);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
    end
`ifdef DIV_REMAINDER_EN
    checks++;
    if (bus.Remainder !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rem: got %0h expected 0", bus.Remainder);
    end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] av[3] = '{16'd200, 16'd255, 16'd50};
    logic [W-1:0] bv[3] = '{16'd10,  16'd7,   16'd25};
    int   lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i]);
      wait_done(0, lat);
      checks++;
      if (lat != 16) begin
        errors++;
        $display("[TB] FAIL basic_latency[%0d]: got %0d expected 16", i, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.Result !== e.q) begin
        errors++;
        $display("[TB] FAIL basic_result[%0d]: got %0d expected %0d", i, bus.Result, e.q);
      end
`ifdef DIV_REMAINDER_EN
      checks++;
      if (bus.Remainder !== e.r) begin
        errors++;
        $display("[TB] FAIL basic_rem[%0d]: got %0d expected %0d", i, bus.Remainder, e.r);
      end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_done_width[%0d]: got %b expected 0", i, bus.done);
      end
    end
  endtask

  // Extreme operands, including a divisor that needs the 17-bit compare and B=0.
  task automatic test_boundaries();
    logic [W-1:0] av[6] = '{16'hFFFF, 16'd0, 16'd5, 16'hFFFF,  16'd1234, 16'hFFFF};
    logic [W-1:0] bv[6] = '{16'd1,    16'd1, 16'd9, 16'd40000, 16'd0,    16'hFFFF};
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      start_op(av[i], bv[i]);
      wait_done(0, lat);
      checks++;
      if (lat != 16) begin
        errors++;
        $display("[TB] FAIL bound_latency[%0d]: got %0d expected 16", i, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.Result !== e.q) begin
        errors++;
        $display("[TB] FAIL bound_result[%0d]: got %0h expected %0h", i, bus.Result, e.q);
      end
`ifdef DIV_REMAINDER_EN
      checks++;
      if (bus.Remainder !== e.r) begin
        errors++;
        $display("[TB] FAIL bound_rem[%0d]: got %0h expected %0h", i, bus.Remainder, e.r);
      end
`endif
    end
  endtask

  task automatic test_ignore_restart();
    int   lat;
    int   extra;
    exp_t e;
    start_op(16'd100, 16'd3);
    repeat (4) @(negedge clk);
    bus.init_in = 1'b1;
    bus.A = 16'd7;
    bus.B = 16'd1;
    @(negedge clk);
    bus.init_in = 1'b0;
    bus.A = 16'd999;
    bus.B = 16'd5;
    wait_done(5, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("[TB] FAIL ignore_latency: got %0d expected 16", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.Result !== e.q) begin
      errors++;
      $display("[TB] FAIL ignore_result: got %0d expected %0d", bus.Result, e.q);
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL ignore_extra_done: got %0d pulses expected 0", extra);
    end
  endtask

  // init_in held high: the second operation starts on the edge after done.
  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    @(negedge clk);
    bus.A = 16'd40;
    bus.B = 16'd6;
    bus.init_in = 1'b1;
    exp_q.push_back(model(16'd40, 16'd6));
    @(posedge clk);
    wait_done(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 16 || bus.Result !== e.q) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d q=%0d expected lat=16 q=%0d", lat, bus.Result, e.q);
    end
    bus.A = 16'd1000;
    bus.B = 16'd7;
    exp_q.push_back(model(16'd1000, 16'd7));
    @(posedge clk);
    #1;
    bus.init_in = 1'b0;
    wait_done(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 16 || bus.Result !== e.q) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d q=%0d expected lat=16 q=%0d", lat, bus.Result, e.q);
    end
  endtask

  task automatic test_reset_abort();
    int   pulses;
    int   lat;
    exp_t e;
    start_op(16'd100, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL abort_done: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (bus.Result !== '0) begin
      errors++;
      $display("[TB] FAIL abort_result: got %0d expected 0", bus.Result);
    end
    start_op(16'd9, 16'd3);
    wait_done(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 16 || bus.Result !== e.q) begin
      errors++;
      $display("[TB] FAIL abort_recover: got lat=%0d q=%0d expected lat=16 q=%0d", lat, bus.Result, e.q);
    end
  endtask

  initial begin
    $display("[TB] div16 testbench starting");
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_restart();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
